// File: rtl/iris_center_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iris_center_pkg : widths, CORDIC constants and helpers for iris_center   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package iris_center_pkg;

  localparam int ANGLE_W     = 12;
  localparam int COORD_W     = 14;
  localparam int RADIUS_W    = 13;
  localparam int TRIG_W      = 16;
  localparam int CORDIC_ITER = 14;
  localparam int LATENCY     = 18;

  localparam int CORDIC_AW   = 18;
  localparam int CORDIC_IW   = 18;
  localparam int ANGLE_SHIFT = CORDIC_AW - ANGLE_W;
  localparam int SUM_W       = COORD_W + 3;

  localparam logic signed [CORDIC_IW-1:0] CORDIC_GAIN = 18'sd9949;
  localparam logic signed [CORDIC_IW-1:0] TRIG_ONE    = 18'sd16384;

  typedef logic signed [TRIG_W-1:0] trig_t;

  // atan(2^-i) expressed in units of 2*pi/2^18
  function automatic logic signed [CORDIC_AW-1:0] atan_lut(input int idx);
    case (idx)
      0:       atan_lut = 18'sd32768;
      1:       atan_lut = 18'sd19344;
      2:       atan_lut = 18'sd10221;
      3:       atan_lut = 18'sd5188;
      4:       atan_lut = 18'sd2604;
      5:       atan_lut = 18'sd1303;
      6:       atan_lut = 18'sd652;
      7:       atan_lut = 18'sd326;
      8:       atan_lut = 18'sd163;
      9:       atan_lut = 18'sd81;
      10:      atan_lut = 18'sd41;
      11:      atan_lut = 18'sd20;
      12:      atan_lut = 18'sd10;
      13:      atan_lut = 18'sd5;
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic trig_t sat_trig(input logic signed [CORDIC_IW-1:0] v);
    if (v > TRIG_ONE)       sat_trig = 16'sd16384;
    else if (v < -TRIG_ONE) sat_trig = -16'sd16384;
    else                    sat_trig = v[TRIG_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1])                  clamp_coord = '0;
    else if (|s[SUM_W-2:COORD_W])    clamp_coord = '1;
    else                             clamp_coord = s[COORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/iris_cordic_sincos.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iris_cordic_sincos : 14-stage pipelined rotation CORDIC, Q1.14 sin/cos   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module iris_cordic_sincos
  import iris_center_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ANGLE_W-1:0] angle_i,
  output trig_t              sin_o,
  output trig_t              cos_o
);

  localparam logic signed [CORDIC_AW-1:0] HALF_PI = 18'sd65536;

  logic signed [CORDIC_AW-1:0] w_ang;
  logic                        w_fold;
  logic signed [CORDIC_IW-1:0] w_x   [CORDIC_ITER+1];
  logic signed [CORDIC_IW-1:0] w_y   [CORDIC_ITER+1];
  logic signed [CORDIC_AW-1:0] w_z   [CORDIC_ITER+1];
  logic                        w_neg [CORDIC_ITER+1];
  logic signed [CORDIC_IW-1:0] w_cos_raw;
  logic signed [CORDIC_IW-1:0] w_sin_raw;
  logic                        w_unused_z;

  assign w_ang  = $signed({angle_i, {ANGLE_SHIFT{1'b0}}});
  assign w_fold = (w_ang > HALF_PI) || (w_ang < -HALF_PI);

  // Subtracting pi modulo 2^18 is just an MSB flip; the negate flag undoes it.
  assign w_x[0]   = CORDIC_GAIN;
  assign w_y[0]   = '0;
  assign w_z[0]   = w_fold ? {~w_ang[CORDIC_AW-1], w_ang[CORDIC_AW-2:0]} : w_ang;
  assign w_neg[0] = w_fold;

  for (genvar i = 0; i < CORDIC_ITER; i++) begin : g_stage
    logic signed [CORDIC_IW-1:0] x_q;
    logic signed [CORDIC_IW-1:0] y_q;
    logic signed [CORDIC_AW-1:0] z_q;
    logic                        neg_q;
    logic signed [CORDIC_IW-1:0] w_xs;
    logic signed [CORDIC_IW-1:0] w_ys;
    logic                        w_up;

    assign w_xs = w_x[i] >>> i;
    assign w_ys = w_y[i] >>> i;
    assign w_up = ~w_z[i][CORDIC_AW-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_q   <= '0;
        y_q   <= '0;
        z_q   <= '0;
        neg_q <= 1'b0;
      end else begin
        x_q   <= w_up ? (w_x[i] - w_ys) : (w_x[i] + w_ys);
        y_q   <= w_up ? (w_y[i] + w_xs) : (w_y[i] - w_xs);
        z_q   <= w_up ? (w_z[i] - atan_lut(i)) : (w_z[i] + atan_lut(i));
        neg_q <= w_neg[i];
      end
    end

    assign w_x[i+1]   = x_q;
    assign w_y[i+1]   = y_q;
    assign w_z[i+1]   = z_q;
    assign w_neg[i+1] = neg_q;
  end

  assign w_cos_raw  = w_neg[CORDIC_ITER] ? -w_x[CORDIC_ITER] : w_x[CORDIC_ITER];
  assign w_sin_raw  = w_neg[CORDIC_ITER] ? -w_y[CORDIC_ITER] : w_y[CORDIC_ITER];
  assign cos_o      = sat_trig(w_cos_raw);
  assign sin_o      = sat_trig(w_sin_raw);
  assign w_unused_z = ^w_z[CORDIC_ITER];

endmodule
`default_nettype wire

// File: rtl/iris_center_cal.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iris_center_cal : projected iris centre from eyeball centre/radius/gaze  |
// | Build option IRIS_CENTER_CLAMP_EN saturates outputs instead of wrapping. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module iris_center_cal
  import iris_center_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ANGLE_W-1:0]  theta,
  input  logic [ANGLE_W-1:0]  phi,
  input  logic [RADIUS_W-1:0] rE,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  output logic [COORD_W-1:0]  iris_center_x,
  output logic [COORD_W-1:0]  iris_center_y
);

  localparam int RE_DLY = CORDIC_ITER + 1;
  localparam int XY_DLY = CORDIC_ITER + 2;
  localparam int P1_W   = 30;
  localparam int P1Q_W  = 20;
  localparam int P2_W   = 36;

  logic [ANGLE_W-1:0]      theta_q;
  logic [ANGLE_W-1:0]      phi_q;
  logic [RADIUS_W-1:0]     re_q;
  logic [COORD_W-1:0]      x_q;
  logic [COORD_W-1:0]      y_q;
  logic [RADIUS_W-1:0]     re_dly_q [RE_DLY];
  logic [COORD_W-1:0]      x_dly_q  [XY_DLY];
  logic [COORD_W-1:0]      y_dly_q  [XY_DLY];
  logic signed [P1Q_W-1:0] p1_q;
  trig_t                   cosp_q;
  trig_t                   sinp_q;
  logic signed [SUM_W-1:0] dx_q;
  logic signed [SUM_W-1:0] dy_q;
  logic [COORD_W-1:0]      ox_q;
  logic [COORD_W-1:0]      oy_q;

  trig_t                   w_sin_t;
  trig_t                   w_cos_t;
  trig_t                   w_sin_p;
  trig_t                   w_cos_p;
  logic signed [P1_W-1:0]  w_p1;
  logic signed [P2_W-1:0]  w_p2;
  logic signed [P2_W-1:0]  w_p2_rnd;
  logic signed [P1_W-1:0]  w_ry;
  logic signed [P1_W-1:0]  w_ry_rnd;
  logic signed [SUM_W-1:0] dx_d;
  logic signed [SUM_W-1:0] dy_d;
  logic signed [SUM_W-1:0] w_sx;
  logic signed [SUM_W-1:0] w_sy;
  logic [COORD_W-1:0]      ox_d;
  logic [COORD_W-1:0]      oy_d;
  logic                    w_unused_bits;
  logic                    w_unused_wrap;

  iris_cordic_sincos u_cordic_theta (
    .clk     (clk),
    .rst     (rst),
    .angle_i (theta_q),
    .sin_o   (w_sin_t),
    .cos_o   (w_cos_t)
  );

  iris_cordic_sincos u_cordic_phi (
    .clk     (clk),
    .rst     (rst),
    .angle_i (phi_q),
    .sin_o   (w_sin_p),
    .cos_o   (w_cos_p)
  );

  // rE*sin(theta) in Q.18, kept as Q.8 by truncation
  assign w_p1 = P1_W'($signed({1'b0, re_dly_q[CORDIC_ITER-1]})) * P1_W'(w_sin_t);

  // (Q.8 * Q1.14) = Q.22 and rE*sin(phi) = Q.18, both rounded half-up to Q.4
  assign w_p2     = P2_W'(p1_q) * P2_W'(cosp_q);
  assign w_p2_rnd = w_p2 + 36'sd131072;
  assign dx_d     = w_p2_rnd[34:18];
  assign w_ry     = P1_W'($signed({1'b0, re_dly_q[RE_DLY-1]})) * P1_W'(sinp_q);
  assign w_ry_rnd = w_ry + 30'sd8192;
  assign dy_d     = {w_ry_rnd[29], w_ry_rnd[29:14]};

  assign w_sx = $signed({3'b000, x_dly_q[XY_DLY-1]}) + dx_q;
  assign w_sy = $signed({3'b000, y_dly_q[XY_DLY-1]}) - dy_q;

`ifdef IRIS_CENTER_CLAMP_EN
  assign ox_d          = clamp_coord(w_sx);
  assign oy_d          = clamp_coord(w_sy);
  assign w_unused_wrap = 1'b0;
`else
  assign ox_d          = w_sx[COORD_W-1:0];
  assign oy_d          = w_sy[COORD_W-1:0];
  assign w_unused_wrap = ^{w_sx[SUM_W-1:COORD_W], w_sy[SUM_W-1:COORD_W]};
`endif

  assign w_unused_bits = ^{w_p1[9:0], w_p2_rnd[35], w_p2_rnd[17:0], w_ry_rnd[13:0], w_cos_t};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta_q <= '0;
      phi_q   <= '0;
      re_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      for (int i = 0; i < RE_DLY; i++) re_dly_q[i] <= '0;
      for (int i = 0; i < XY_DLY; i++) begin
        x_dly_q[i] <= '0;
        y_dly_q[i] <= '0;
      end
      p1_q   <= '0;
      cosp_q <= '0;
      sinp_q <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
    end else begin
      theta_q <= theta;
      phi_q   <= phi;
      re_q    <= rE;
      x_q     <= x;
      y_q     <= y;
      re_dly_q[0] <= re_q;
      for (int i = 1; i < RE_DLY; i++) re_dly_q[i] <= re_dly_q[i-1];
      x_dly_q[0] <= x_q;
      y_dly_q[0] <= y_q;
      for (int i = 1; i < XY_DLY; i++) begin
        x_dly_q[i] <= x_dly_q[i-1];
        y_dly_q[i] <= y_dly_q[i-1];
      end
      p1_q   <= w_p1[29:10];
      cosp_q <= w_cos_p;
      sinp_q <= w_sin_p;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
    end
  end

  assign iris_center_x = ox_q;
  assign iris_center_y = oy_q;

endmodule
`default_nettype wire

// File: tb/tb_iris_center_cal.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iris_center_cal : directed + random bench against a real-valued model |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_iris_center_cal;

  localparam real PI  = 3.14159265358979;
  localparam int  LAT = 18;
  localparam int  HN  = 1024;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [11:0] theta = '0;
  logic [11:0] phi   = '0;
  logic [12:0] rE    = '0;
  logic [13:0] x     = '0;
  logic [13:0] y     = '0;
  logic [13:0] iris_center_x;
  logic [13:0] iris_center_y;

  int errors = 0;
  int checks = 0;
  int ecnt   = 40;

  // what the DUT saw at each rising edge
  logic        h_rst [HN];
  logic [11:0] h_th  [HN];
  logic [11:0] h_ph  [HN];
  logic [12:0] h_re  [HN];
  logic [13:0] h_x   [HN];
  logic [13:0] h_y   [HN];

  always #5 clk = ~clk;

  iris_center_cal dut (
    .clk           (clk),
    .rst           (rst),
    .theta         (theta),
    .phi           (phi),
    .rE            (rE),
    .x             (x),
    .y             (y),
    .iris_center_x (iris_center_x),
    .iris_center_y (iris_center_y)
  );

  function automatic real ang(input logic [11:0] a);
    return $itor($signed(a)) * 2.0 * PI / 4096.0;
  endfunction

  function automatic real model_x(input int e);
    return $itor(h_x[e]) + $itor(h_re[e]) * $sin(ang(h_th[e])) * $cos(ang(h_ph[e]));
  endfunction

  function automatic real model_y(input int e);
    return $itor(h_y[e]) - $itor(h_re[e]) * $sin(ang(h_ph[e]));
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input real ex);
    real e;
    real d;
    bit  ok;
    e = ex;
`ifdef IRIS_CENTER_CLAMP_EN
    if (e < 0.0)     e = 0.0;
    if (e > 16383.0) e = 16383.0;
    d = $itor(obs) - e;
`else
    d = $itor(obs) - e;
    while (d > 8192.0)  d = d - 16384.0;
    while (d < -8192.0) d = d + 16384.0;
`endif
    ok = (d <= 2.0) && (d >= -2.0);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0.2f (+-2)", tag, obs, e);
    end
  endtask

  // Output after edge e comes from the set sampled LAT-1 edges earlier,
  // unless a reset was seen anywhere in that window.
  task automatic check_pipe();
    int src;
    bit flushed;
    src     = ecnt - (LAT - 1);
    flushed = rst;
    for (int k = src; k <= ecnt; k++) if (h_rst[k]) flushed = 1'b1;
    if (flushed) begin
      check_eq("zero_x", int'(iris_center_x), 0);
      check_eq("zero_y", int'(iris_center_y), 0);
    end else begin
      check_near("pipe_x", int'(iris_center_x), model_x(src));
      check_near("pipe_y", int'(iris_center_y), model_y(src));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ecnt++;
    h_rst[ecnt] = rst;
    h_th[ecnt]  = theta;
    h_ph[ecnt]  = phi;
    h_re[ecnt]  = rE;
    h_x[ecnt]   = x;
    h_y[ecnt]   = y;
    #1;
    check_pipe();
  endtask

  task automatic apply(input logic [11:0] th, input logic [11:0] ph,
                       input logic [12:0] r, input logic [13:0] xx, input logic [13:0] yy);
    theta = th;
    phi   = ph;
    rE    = r;
    x     = xx;
    y     = yy;
    repeat (LAT) tick();
  endtask

  initial begin
    for (int i = 0; i < HN; i++) begin
      h_rst[i] = 1'b1;
      h_th[i]  = '0;
      h_ph[i]  = '0;
      h_re[i]  = '0;
      h_x[i]   = '0;
      h_y[i]   = '0;
    end

    rE = 13'd1320; x = 14'd3255; y = 14'd1389; theta = 12'd0; phi = 12'd0;
    #2;
    check_eq("rst_x", int'(iris_center_x), 0);
    check_eq("rst_y", int'(iris_center_y), 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (LAT - 1) tick();
    tick();
    check_eq("t0_x", int'(iris_center_x), 3255);
    check_eq("t0_y", int'(iris_center_y), 1389);

    apply(12'd1024, 12'd0, 13'd1320, 14'd3255, 14'd1389);
    check_near("pi2_x", int'(iris_center_x), 4575.0);
    check_near("pi2_y", int'(iris_center_y), 1389.0);

    apply(12'd3072, 12'd1024, 13'd1320, 14'd3255, 14'd1389);
    check_near("cos0_x", int'(iris_center_x), 3255.0);
    check_near("cos0_y", int'(iris_center_y), 69.0);

    apply(12'd2048, 12'd3072, 13'd1320, 14'd3255, 14'd1389);
    check_near("negpi_x", int'(iris_center_x), 3255.0);
    check_near("negpi_y", int'(iris_center_y), 2709.0);

    apply(12'd1024, 12'd0, 13'd1320, 14'd16000, 14'd1389);
`ifdef IRIS_CENTER_CLAMP_EN
    check_near("ovf_x", int'(iris_center_x), 16383.0);
`else
    check_near("ovf_x", int'(iris_center_x), 936.0);
`endif
    check_near("ovf_y", int'(iris_center_y), 1389.0);

    for (int n = 0; n < 200; n++) begin
      theta = 12'($urandom());
      phi   = 12'($urandom());
      rE    = 13'($urandom_range(2400, 0));
      x     = 14'($urandom());
      y     = 14'($urandom());
      if (n == 100) begin
        rst = 1'b1;
        #1;
        check_eq("async_rst_x", int'(iris_center_x), 0);
        check_eq("async_rst_y", int'(iris_center_y), 0);
      end
      if (n == 104) rst = 1'b0;
      tick();
    end
    repeat (LAT + 2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iris_center_cal.md
# iris_center_cal

Fixed-point gaze-geometry block. It takes the eyeball centre (x, y), the eyeball radius rE and two gaze angles (theta = horizontal, phi = vertical), and produces the projected iris centre in image coordinates. It sits after the eye-detection/gaze-estimation stage and feeds the iris-matching datapath. It is fully pipelined: it accepts one input set per clock and has fixed latency.

## Interface
Parameters: none (all widths fixed; constants live in the package).
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- theta  input  12  horizontal gaze angle, two's complement, 1 LSB = 2π/4096 (range −π..π−LSB)
- phi  input  12  vertical gaze angle, same encoding as theta
- rE  input  13  eyeball radius, unsigned Q9.4 (e.g. 1320 = 82.5)
- x  input  14  eyeball centre x, unsigned Q10.4 (e.g. 3255 = 203.44)
- y  input  14  eyeball centre y, unsigned Q10.4
- iris_center_x  output  14  iris centre x, unsigned Q10.4
- iris_center_y  output  14  iris centre y, unsigned Q10.4

## Operation
- Model:
  - iris_center_x = x + rE·sin(theta)·cos(phi)
  - iris_center_y = y − rE·sin(phi)
- sin/cos:
  - Computed by rotation-mode CORDIC, 14 iterations, 18-bit internal angle (input angle left-shifted by 6).
  - Quadrant folding: if |angle| > π/2, rotate by π and negate both results.
  - Start vector x0 = 9949 (K·2^14), y0 = 0.
  - Results are signed Q1.14 (16 bit), saturated to ±16384.
- Products:
  - rE·sin(theta) is a signed Q10.18 product, truncated to Q10.8.
  - Multiply that by cos(phi), then round half-up to Q.4.
  - rE·sin(phi) is rounded half-up to Q.4.
- Final sum is formed in 17-bit signed. Overflow handling depends on CLAMP (see Configuration).
- Accuracy: each output is within ±2 LSB of the exact real-valued result.
- No handshake: inputs are sampled every cycle, and an output changes only as a consequence of an input change.

## Timing
- Latency: 18 rising edges from the edge that samples an input set to the edge at which its results appear on the outputs.
  - 1 cycle: input registers
  - 14 cycles: CORDIC stages (both angles in parallel)
  - 1 cycle: first multiply
  - 1 cycle: second multiply / sin(phi) scaling
  - 1 cycle: add/round/overflow output register
- Throughput: 1 result per clock. Consecutive input sets produce consecutive outputs with no bubbles.
- Reset:
  - Asserting rst clears every pipeline register immediately; both outputs become 0.
  - While rst is high the outputs stay 0.
  - After release, outputs stay 0 until the first sampled input set reaches the output 18 edges later. The intermediate pipeline content is zeros and produces 0 + 0.
- Reset mid-operation discards all in-flight results. None are emitted after release.

## Configuration
- IRIS_CENTER_CLAMP_EN defined:
  - Final sums are saturated to 0..16383.
  - Negative results give 0; results > 16383 give 16383.
- Not defined:
  - Final sums wrap modulo 2^14 (low 14 bits kept).
  - Logic is otherwise identical and latency is unchanged.

## Structure
- Package iris_center_pkg holds:
  - width constants (ANGLE_W=12, COORD_W=14, RADIUS_W=13, TRIG_W=16, CORDIC_ITER=14, LATENCY=18)
  - CORDIC gain constant 9949
  - the 14-entry arctangent table in 2π/2^18 units
- Sub-module iris_cordic_sincos: pipelined 14-stage sin/cos unit with quadrant folding. It is instantiated twice (theta, phi) and has clk/rst, a 12-bit angle in and 16-bit sin/cos out.

## Test plan
- rE=1320, x=3255, y=1389, theta=0, phi=0 held; release rst → outputs 0 until latency elapses, then iris_center_x=3255, iris_center_y=1389.
- Same, theta=1024 (π/2), phi=0 → iris_center_x=4575±2, iris_center_y=1389.
- theta=−1024, phi=1024 → iris_center_x=3255±2 (cos φ≈0), iris_center_y=69±2.
- theta=2048 (−π), phi=−1024 → iris_center_x=3255±2, iris_center_y=2709±2.
- x=16000, rE=1320, theta=1024, phi=0 → 16383 with IRIS_CENTER_CLAMP_EN; 936±2 without.
- A new random input set every cycle for 200 cycles, with rst pulsed mid-stream → each output matches the floating-point model ±2 LSB exactly 18 cycles later; outputs are 0 during reset; no stale results after release.
